branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor of the single-cycle branch decoder.
- Compares rs1/rs2 internally at XLEN width, decodes funct3, computes the B-type target, and registers the result behind a valid/ready handshake.
- Trains a direct-mapped 2-bit branch history table (BHT) that fetch reads for prediction; flags a mispredict and the redirect PC.
- Sits between decode/operand read and the PC-select logic.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries; power of 2, minimum 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  processor clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a branch is presented.
- in_ready  out  1  unit accepts the branch this cycle.
- insn  in  32  branch instruction; funct3 = insn[14:12]; opcode is not checked.
- pc  in  XLEN  PC of the branch.
- rs1_val  in  XLEN  source operand 1.
- rs2_val  in  XLEN  source operand 2.
- pred_taken  in  1  prediction fetch used for this branch.
- out_valid  out  1  registered result valid.
- out_ready  in  1  consumer takes the result.
- br_taken  out  1  branch resolved taken.
- br_target  out  XLEN  pc + sext(B-immediate).
- redirect_pc  out  XLEN  br_taken ? br_target : pc+4.
- mispredict  out  1  br_taken != pred_taken.
- illegal  out  1  funct3 is 010 or 011.
- lookup_pc  in  XLEN  fetch-side BHT read address.
- lookup_taken  out  1  MSB of BHT[lookup_pc index]; combinational.
- br_count  out  CNT_W  resolved branches (optional feature).
- mispredict_count  out  CNT_W  mispredicts (optional feature).

Behaviour:
- Reset:
  - out_valid=0; br_taken, mispredict and illegal = 0; br_target and redirect_pc = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Counters = 0.
  - An in-flight result is dropped.
- Handshake:
  - in_ready = ~out_valid | out_ready, so a full single-entry register with out_ready=1 accepts back-to-back.
  - Accept = in_valid & in_ready.
  - Output hold = out_valid & ~out_ready; all outputs stay stable while held.
  - out_valid sets on accept and clears on out_ready without a new accept.
- Latency: exactly 1 cycle from accept to out_valid.
- Compare, funct3:
  - 000 beq: taken = EQ.
  - 001 bne: taken = ~EQ.
  - 100 blt: taken = LS, signed.
  - 101 bge: taken = ~LS.
  - 110 bltu: taken = LU, unsigned.
  - 111 bgeu: taken = ~LU.
- Illegal funct3 (010, 011): illegal=1, br_taken=0, redirect_pc = pc+4, mispredict = pred_taken; BHT is not updated.
- Immediate:
  - imm = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}, sign-extended to XLEN.
  - All adds are modulo 2^XLEN (wrap-around, no flag).
- BHT:
  - Index = pc[IDXW+1:2], where IDXW = log2(BHT_DEPTH); the same slice of lookup_pc is used for reads.
  - On a legal accept, the entry saturates up (max 11) if taken, down (min 00) if not taken.
  - A read and an update to the same index in the same cycle return the old value (no bypass).
- Simultaneous reset with in_valid: reset wins; nothing is accepted.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - br_count increments on each output handshake (out_valid & out_ready), legal branches only.
  - mispredict_count increments on each output handshake with mispredict=1, including illegal.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both ports stay present and are tied to 0; no counter flops.

Test Plan:
- beq, rs1=rs2=0x5, pc=0x100, imm=+8, pred_taken=0 -> one cycle later: out_valid=1, br_taken=1, br_target=0x108, redirect_pc=0x108, mispredict=1; BHT[0x100] becomes 10, so lookup_pc=0x100 gives lookup_taken=1.
- blt vs bltu, rs1=0xFFFFFFFF, rs2=0x1 -> blt taken=1; bltu taken=0; bge taken=0; bgeu taken=1.
- Backpressure: out_ready=0 after the first accept -> in_ready=0, outputs held for 3 cycles; out_ready=1 -> next branch accepted the same cycle, no drop or duplicate.
- pc=0xFFFFFFFC, imm=+8 -> br_target=0x00000004; bne not-taken, pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- funct3=010, pred_taken=1 -> illegal=1, br_taken=0, mispredict=1; BHT entry unchanged.
- Saturation: five taken at the same index -> entry 11; one not-taken -> 10, lookup_taken still 1. Assert reset with out_valid=1 -> out_valid=0 next cycle, entry back to 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, computes the B-type target, registers the result behind
// a valid/ready handshake and trains a 2-bit BHT. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      insn,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             illegal,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDXW = $clog2(BHT_DEPTH);

    logic [2:0]      funct3;
    logic            eq;
    logic            ls;
    logic            lu;
    logic            taken_c;
    logic            illegal_c;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] seq_pc;
    logic            accept;
    logic [IDXW-1:0] upd_idx;
    logic [IDXW-1:0] rd_idx;
    logic [1:0]      bht [BHT_DEPTH];
    logic [1:0]      cur_ctr;
    logic [1:0]      nxt_ctr;
    logic            unused_bits;

    assign funct3 = insn[14:12];
    assign eq     = (rs1_val == rs2_val);
    assign ls     = ($signed(rs1_val) < $signed(rs2_val));
    assign lu     = (rs1_val < rs2_val);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3)
            3'b000:  taken_c = eq;
            3'b001:  taken_c = ~eq;
            3'b100:  taken_c = ls;
            3'b101:  taken_c = ~ls;
            3'b110:  taken_c = lu;
            3'b111:  taken_c = ~lu;
            default: illegal_c = 1'b1;
        endcase
    end

    assign imm      = {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign target_c = pc + imm;
    assign seq_pc   = pc + XLEN'(4);

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    assign upd_idx      = pc[IDXW+1:2];
    assign rd_idx       = lookup_pc[IDXW+1:2];
    assign lookup_taken = bht[rd_idx][1];
    assign cur_ctr      = bht[upd_idx];

    always_comb begin
        nxt_ctr = cur_ctr;
        if (taken_c) begin
            if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'b01;
        end else begin
            if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'b01;
        end
    end

    // Output register: loads on accept, otherwise only out_valid can drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            br_taken    <= 1'b0;
            br_target   <= '0;
            redirect_pc <= '0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            br_taken    <= taken_c & ~illegal_c;
            br_target   <= target_c;
            redirect_pc <= (taken_c & ~illegal_c) ? target_c : seq_pc;
            mispredict  <= (taken_c & ~illegal_c) != pred_taken;
            illegal     <= illegal_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && !illegal_c) begin
            bht[upd_idx] <= nxt_ctr;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;
    logic             out_hs;

    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (out_hs) begin
            if (!illegal && (br_cnt_q != {CNT_W{1'b1}})) br_cnt_q <= br_cnt_q + 1'b1;
            if (mispredict && (mp_cnt_q != {CNT_W{1'b1}})) mp_cnt_q <= mp_cnt_q + 1'b1;
        end
    end

    assign br_count         = br_cnt_q;
    assign mispredict_count = mp_cnt_q;
`else
    assign br_count         = '0;
    assign mispredict_count = '0;
`endif

    assign unused_bits = ^{insn[6:0], lookup_pc[XLEN-1:IDXW+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic        illegal;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    int tests_run;
    int tests_failed;

    branch_resolve_unit dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .insn             (insn),
        .pc               (pc),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .pred_taken       (pred_taken),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .redirect_pc      (redirect_pc),
        .mispredict       (mispredict),
        .illegal          (illegal),
        .lookup_pc        (lookup_pc),
        .lookup_taken     (lookup_taken),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Presents one branch at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic pt);
        @(negedge clk);
        insn = i; pc = p; rs1_val = a; rs2_val = b; pred_taken = pt; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_lookup(input string name, input logic [31:0] lpc, input logic exp);
        lookup_pc = lpc;
        #1;
        tests_run++;
        if (lookup_taken !== exp) begin
            tests_failed++;
            $display("FAIL %s: lookup_taken=%0b expected %0b", name, lookup_taken, exp);
        end
    endtask

    task automatic test_reset();
        // Reset asserted together with a valid branch: nothing may be accepted.
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        insn = mk_b(13'd8, 3'b000); pc = 32'h100; rs1_val = 5; rs2_val = 5; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        tests_run++;
        if ({out_valid, br_taken, mispredict, illegal} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {out_valid, br_taken, mispredict, illegal});
        end
        tests_run++;
        if (br_target !== 32'h0 || redirect_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pcs: target=%h redirect=%h expected 0", br_target, redirect_pc);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests_run++;
        if (br_count !== 32'h0 || mispredict_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_counts: br=%0d mp=%0d expected 0", br_count, mispredict_count);
        end
        check_lookup("reset_bht", 32'h100, 1'b0);
    endtask

    task automatic test_beq();
        do_reset();
        send(mk_b(13'd8, 3'b000), 32'h100, 32'h5, 32'h5, 1'b0);
        tests_run++;
        if ({out_valid, br_taken, mispredict, illegal} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL beq_flags: got %b expected 1110",
                     {out_valid, br_taken, mispredict, illegal});
        end
        tests_run++;
        if (br_target !== 32'h108 || redirect_pc !== 32'h108) begin
            tests_failed++;
            $display("FAIL beq_pcs: target=%h redirect=%h expected 108", br_target, redirect_pc);
        end
        check_lookup("beq_bht", 32'h100, 1'b1);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL beq_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_compare();
        logic [2:0] f3   [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic       expt [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send(mk_b(13'h1ff0, f3[k]), 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0);
            tests_run++;
            if (br_taken !== expt[k] || out_valid !== 1'b1 || illegal !== 1'b0) begin
                tests_failed++;
                $display("FAIL cmp_f3_%0d: taken=%b valid=%b illegal=%b expected taken %b",
                         f3[k], br_taken, out_valid, illegal, expt[k]);
            end
            tests_run++;
            if (redirect_pc !== (expt[k] ? 32'h30 : 32'h44) || br_target !== 32'h30) begin
                tests_failed++;
                $display("FAIL cmp_pc_f3_%0d: redirect=%h target=%h", f3[k], redirect_pc,
                         br_target);
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        do_reset();
        out_ready = 1'b0;
        send(mk_b(13'd16, 3'b000), 32'h10, 32'h1, 32'h1, 1'b1);
        insn = mk_b(13'h1ffc, 3'b001); pc = 32'h24; rs1_val = 1; rs2_val = 1; pred_taken = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || br_taken !== 1'b1 ||
                br_target !== 32'h20 || redirect_pc !== 32'h20 || mispredict !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: rdy=%b v=%b t=%b tgt=%h rd=%h mp=%b", c, in_ready,
                         out_valid, br_taken, br_target, redirect_pc, mispredict);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || br_taken !== 1'b0 || redirect_pc !== 32'h28 ||
            br_target !== 32'h20 || mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_result: v=%b t=%b rd=%h tgt=%h mp=%b expected 1 0 28 20 0",
                     out_valid, br_taken, redirect_pc, br_target, mispredict);
        end
        guard = 0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_duplicate: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send(mk_b(13'd8, 3'b000), 32'hFFFF_FFFC, 32'h7, 32'h7, 1'b1);
        tests_run++;
        if (br_target !== 32'h4 || redirect_pc !== 32'h4 || br_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_taken: target=%h redirect=%h taken=%b expected 4 4 1",
                     br_target, redirect_pc, br_taken);
        end
        send(mk_b(13'd8, 3'b001), 32'hFFFF_FFFC, 32'h7, 32'h7, 1'b1);
        tests_run++;
        if (redirect_pc !== 32'h0 || br_taken !== 1'b0 || mispredict !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_seq: redirect=%h taken=%b mp=%b expected 0 0 1",
                     redirect_pc, br_taken, mispredict);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send(mk_b(13'd8, 3'b010), 32'h80, 32'h3, 32'h3, 1'b1);
        tests_run++;
        if ({out_valid, illegal, br_taken, mispredict} !== 4'b1101 || redirect_pc !== 32'h84)
        begin
            tests_failed++;
            $display("FAIL illegal_010: v/ill/t/mp=%b redirect=%h expected 1101 84",
                     {out_valid, illegal, br_taken, mispredict}, redirect_pc);
        end
        send(mk_b(13'd8, 3'b011), 32'h80, 32'h3, 32'h4, 1'b0);
        tests_run++;
        if ({illegal, br_taken, mispredict} !== 3'b100) begin
            tests_failed++;
            $display("FAIL illegal_011: ill/t/mp=%b expected 100",
                     {illegal, br_taken, mispredict});
        end
        check_lookup("illegal_bht_read", 32'h80, 1'b0);
        // Entry must still be 01, so one taken branch moves it to 10.
        send(mk_b(13'd8, 3'b000), 32'h80, 32'h3, 32'h3, 1'b0);
        check_lookup("illegal_bht_kept", 32'h80, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) send(mk_b(13'd8, 3'b000), 32'h30, 32'h1, 32'h1, 1'b1);
        send(mk_b(13'd8, 3'b001), 32'h30, 32'h1, 32'h1, 1'b1);
        check_lookup("sat_after_one_nt", 32'h30, 1'b1);
        send(mk_b(13'd8, 3'b001), 32'h30, 32'h1, 32'h1, 1'b1);
        check_lookup("sat_after_two_nt", 32'h30, 1'b0);
        for (int k = 0; k < 2; k++) send(mk_b(13'd8, 3'b000), 32'h30, 32'h1, 32'h1, 1'b1);
        out_ready = 1'b0;
        send(mk_b(13'd8, 3'b000), 32'h30, 32'h1, 32'h1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_valid: out_valid=%b expected 1", out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drop: out_valid=%b expected 0", out_valid);
        end
        check_lookup("reset_bht_nt", 32'h30, 1'b0);
        send(mk_b(13'd8, 3'b000), 32'h30, 32'h1, 32'h1, 1'b1);
        check_lookup("reset_bht_01", 32'h30, 1'b1);
    endtask

    task automatic test_perf();
        logic [31:0] exp_br;
        logic [31:0] exp_mp;
`ifdef BRU_PERF_CNT_EN
        exp_br = 2;
        exp_mp = 2;
`else
        exp_br = 0;
        exp_mp = 0;
`endif
        do_reset();
        send(mk_b(13'd8, 3'b000), 32'h200, 32'h1, 32'h1, 1'b0);
        send(mk_b(13'd8, 3'b001), 32'h204, 32'h1, 32'h1, 1'b0);
        send(mk_b(13'd8, 3'b010), 32'h208, 32'h1, 32'h1, 1'b1);
        @(negedge clk);
        tests_run++;
        if (br_count !== exp_br || mispredict_count !== exp_mp) begin
            tests_failed++;
            $display("FAIL perf_counts: br=%0d mp=%0d expected %0d %0d", br_count,
                     mispredict_count, exp_br, exp_mp);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; insn = '0; pc = '0;
        rs1_val = '0; rs2_val = '0; pred_taken = 1'b0; lookup_pc = '0;
        test_reset();
        test_beq();
        test_compare();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_saturation();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
